stage_reg: RTL and testbench
============================

STAGE_REG -- requirements
Module: stage_reg

Interface
REQ-001 Parameter DATA_W, default 81, meaning payload width; 81 = aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1.
REQ-002 Parameter NOP_VALUE, default all-zero, DATA_W bits, meaning bubble payload driven on reset and flush.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous squash of all held entries.
REQ-006 Port in_valid  input  1  upstream offers in_data.
REQ-007 Port in_ready  output  1  stage accepts in_data this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port out_valid  output  1  out_data holds a live entry.
REQ-010 Port out_ready  input  1  downstream consumes this cycle; low = stall.
REQ-011 Port out_data  output  DATA_W  registered payload to next stage.

Function
REQ-012 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-013 Latency SHALL be exactly 1 cycle from transfer-in to out_valid when the stage is empty.
REQ-014 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-015 Entries SHALL leave in arrival order; no entry dropped or duplicated except by flush.
REQ-016 When not live, out_data SHALL equal NOP_VALUE, so a bubble reaches EX as a NOP.
REQ-017 flush SHALL take priority over every other event: next cycle out_valid=0, all entries cleared, out_data=NOP_VALUE, and any in_data offered in the flush cycle discarded.
REQ-018 Simultaneous transfer-out and transfer-in on a full main register SHALL replace it with the new entry, with no bubble.
REQ-019 out_valid SHALL fall after transfer-out when no new entry arrives in the same cycle; out_data then returns to NOP_VALUE.

Reset
REQ-020 Asserting rst SHALL immediately clear out_valid and skid-valid to 0, load out_data with NOP_VALUE and drive in_ready to 1, independent of clk.
REQ-021 Deassertion SHALL take effect at the first rising edge of clk after it; a transfer in progress when rst asserts SHALL be lost.

Configuration
REQ-022 Macro STAGE_REG_SKID_EN SHALL select the buffering mode.
REQ-023 Without STAGE_REG_SKID_EN: single register; in_ready = !out_valid || out_ready, combinational; full throughput only while out_ready=1.
REQ-024 With STAGE_REG_SKID_EN: main register plus one skid entry; in_ready SHALL be a flop equal to "skid empty", with no combinational path from out_ready.
REQ-025 Skid mode: on a transfer-in while main is live and out_ready=0, the entry SHALL go to skid and in_ready SHALL fall next cycle.
REQ-026 Skid mode: on a transfer-out with skid full, skid SHALL move to main and in_ready SHALL rise next cycle.
REQ-027 Skid mode: sustained out_ready=1 SHALL give one transfer per cycle; capacity SHALL be 2 and never exceeded.

Structure
REQ-028 The NOP payload fields (EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, WriteDisable) and the field widths SHALL come from the shared defines package; NOP_VALUE SHALL be built from them at instantiation.
REQ-029 The skid entry SHALL be a sub-module stage_reg_skid (valid flag + DATA_W register, load/clear controls), instantiated only under STAGE_REG_SKID_EN.
REQ-030 id_ex-style stages SHALL be built as stage_reg instances with packed payloads.

Verification
REQ-031 Reset: rst=1 mid-stream with out_valid=1 -> same cycle out_valid=0, out_data=NOP_VALUE, in_ready=1.
REQ-032 Streaming: in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, first one cycle after the first transfer-in.
REQ-033 Stall: load 0xA, hold out_ready=0 for 3 cycles, offer 0xB -> out_data stays 0xA; no skid: in_ready=0; skid: 0xB stored, in_ready=0 next cycle; release -> 0xA then 0xB.
REQ-034 Flush: main=0xA, skid=0xB, flush=1 with in_valid=1, data 0xC -> next cycle out_valid=0, out_data=NOP_VALUE, 0xC never emitted.
REQ-035 Random: random in_valid/out_ready, 1000 cycles, both modes -> scoreboard order exact; capacity <= 1 (no skid) or <= 2 (skid); skid in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/stage_reg_pkg.sv
// Shared defines for pipeline stage registers: ID/EX field widths, NOP field
// values and the packed ID/EX payload used to build the bubble value.
package stage_reg_pkg;

  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned ALUSEL_W   = 3;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ID_EX_W    = ALUOP_W + ALUSEL_W + 2 * REG_W + REG_ADDR_W + 1;

  localparam logic [ALUOP_W-1:0]    EXE_NOP_OP    = ALUOP_W'(0);
  localparam logic [ALUSEL_W-1:0]   EXE_RES_NOP   = ALUSEL_W'(0);
  localparam logic [REG_W-1:0]      ZERO_WORD     = REG_W'(0);
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = REG_ADDR_W'(0);
  localparam logic                  WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [REG_W-1:0]      reg1;
    logic [REG_W-1:0]      reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
  } id_ex_t;

  // Bubble payload: decodes in EX as an operation with no side effects.
  function automatic id_ex_t id_ex_nop();
    id_ex_t p;
    p.aluop  = EXE_NOP_OP;
    p.alusel = EXE_RES_NOP;
    p.reg1   = ZERO_WORD;
    p.reg2   = ZERO_WORD;
    p.wd     = NOP_REG_ADDR;
    p.wreg   = WRITE_DISABLE;
    return p;
  endfunction

  localparam id_ex_t ID_EX_NOP = id_ex_nop();

endpackage

// File: rtl/stage_reg_skid.sv
// Single skid entry for stage_reg: valid flag plus payload register with
// load/clear controls; cleared entries hold the NOP payload.
module stage_reg_skid
  import stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(ID_EX_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // clear wins over load so a flush can never leave a stale entry behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= NOP_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= NOP_VALUE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/stage_reg.sv
// Valid/ready pipeline stage register with flush and NOP bubbles.
// Define STAGE_REG_SKID_EN for a registered in_ready backed by one skid entry.
module stage_reg
  import stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(ID_EX_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              take_in;
  logic              take_out;
  logic              main_valid_nxt;
  logic [DATA_W-1:0] main_data_nxt;

  assign take_in  = in_valid && in_ready;
  assign take_out = out_valid && out_ready;

`ifdef STAGE_REG_SKID_EN

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_clear;
  logic              ready_nxt;

  stage_reg_skid #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_data),
    .valid (skid_valid),
    .data  (skid_data)
  );

  // Main refills from skid first (oldest entry), else from the input.
  // in_ready only ever follows the skid occupancy, never out_ready directly.
  always_comb begin
    main_valid_nxt = out_valid;
    main_data_nxt  = out_data;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    ready_nxt      = in_ready;
    if (flush) begin
      main_valid_nxt = 1'b0;
      main_data_nxt  = NOP_VALUE;
      skid_clear     = 1'b1;
      ready_nxt      = 1'b1;
    end else begin
      if (!out_valid || take_out) begin
        if (skid_valid) begin
          main_valid_nxt = 1'b1;
          main_data_nxt  = skid_data;
          skid_clear     = 1'b1;
        end else if (take_in) begin
          main_valid_nxt = 1'b1;
          main_data_nxt  = in_data;
        end else begin
          main_valid_nxt = 1'b0;
          main_data_nxt  = NOP_VALUE;
        end
      end else if (take_in) begin
        skid_load = 1'b1;
      end
      ready_nxt = !((skid_valid && !skid_clear) || skid_load);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= ready_nxt;
    end
  end

`else

  assign in_ready = !out_valid || out_ready;

  // Single entry: a new arrival may replace a departing one in the same cycle.
  always_comb begin
    main_valid_nxt = out_valid;
    main_data_nxt  = out_data;
    if (flush) begin
      main_valid_nxt = 1'b0;
      main_data_nxt  = NOP_VALUE;
    end else if (take_in) begin
      main_valid_nxt = 1'b1;
      main_data_nxt  = in_data;
    end else if (take_out) begin
      main_valid_nxt = 1'b0;
      main_data_nxt  = NOP_VALUE;
    end
  end

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
    end else begin
      out_valid <= main_valid_nxt;
      out_data  <= main_data_nxt;
    end
  end

endmodule

// File: tb/tb_stage_reg.sv
// Self-checking bench for stage_reg: queue-based reference model, per-cycle
// compare, directed literal expectations and randomized traffic.
module tb_stage_reg;
  import stage_reg_pkg::*;

  localparam int unsigned DW = ID_EX_W;
  localparam logic [DW-1:0] NOP = DW'(ID_EX_NOP);
`ifdef STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference: entries held, oldest first; capacity 2 with skid, else 1.
  logic [DW-1:0] q[$];
  int checks = 0;
  int failures = 0;

  logic          lit_en = 1'b0;
  string         lit_name = "";
  logic          lit_valid = 1'b0;
  logic          lit_ready = 1'b0;
  logic [DW-1:0] lit_data = '0;

  function automatic logic model_ready(input int sz, input logic ordy);
    return SKID ? (sz < 2) : ((sz == 0) || ordy);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic acc;
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && model_ready(q.size(), out_ready);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  end

  task automatic check1(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic          exp_v;
    logic          exp_r;
    logic [DW-1:0] exp_d;
    exp_v = (q.size() != 0);
    exp_d = exp_v ? q[0] : NOP;
    exp_r = model_ready(q.size(), out_ready);
    check1("model out_valid", DW'(out_valid), DW'(exp_v));
    check1("model out_data", out_data, exp_d);
    check1("model in_ready", DW'(in_ready), DW'(exp_r));
    if (lit_en) begin
      check1({lit_name, " out_valid"}, DW'(out_valid), DW'(lit_valid));
      check1({lit_name, " out_data"}, out_data, lit_data);
      check1({lit_name, " in_ready"}, DW'(in_ready), DW'(lit_ready));
    end
  end

  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    lit_en    = 1'b0;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic lit(input string name, input logic v, input logic [DW-1:0] d, input logic r);
    lit_name  = name;
    lit_valid = v;
    lit_data  = d;
    lit_ready = r;
    lit_en    = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    lit("reset", 1'b0, NOP, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    tick(1'b0, '0, 1'b1, 1'b0);

    // Streaming 1..4 with downstream always ready
    tick(1'b1, DW'(1), 1'b1, 1'b0);
    tick(1'b1, DW'(2), 1'b1, 1'b0); lit("stream1", 1'b1, DW'(1), 1'b1);
    tick(1'b1, DW'(3), 1'b1, 1'b0); lit("stream2", 1'b1, DW'(2), 1'b1);
    tick(1'b1, DW'(4), 1'b1, 1'b0); lit("stream3", 1'b1, DW'(3), 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);     lit("stream4", 1'b1, DW'(4), 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);     lit("stream_end", 1'b0, NOP, 1'b1);

    // Stall: A held while B is offered
    tick(1'b1, DW'(32'hA), 1'b0, 1'b0);
    tick(1'b1, DW'(32'hB), 1'b0, 1'b0); lit("stall1", 1'b1, DW'(32'hA), SKID);
    tick(1'b1, DW'(32'hB), 1'b0, 1'b0); lit("stall2", 1'b1, DW'(32'hA), 1'b0);
    tick(1'b1, DW'(32'hB), 1'b0, 1'b0); lit("stall3", 1'b1, DW'(32'hA), 1'b0);
    tick(1'b1, DW'(32'hB), 1'b1, 1'b0); lit("release", 1'b1, DW'(32'hA), !SKID);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("drain_b", 1'b1, DW'(32'hB), 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("drain_end", 1'b0, NOP, 1'b1);

    // Flush with full stage and a competing offer
    tick(1'b1, DW'(32'hA), 1'b0, 1'b0);
    tick(1'b1, DW'(32'hB), 1'b0, 1'b0);
    tick(1'b1, DW'(32'hC), 1'b0, 1'b1); lit("pre_flush", 1'b1, DW'(32'hA), 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("flush1", 1'b0, NOP, 1'b1);
    tick(1'b1, DW'(32'hD), 1'b1, 1'b1); lit("flush2", 1'b0, NOP, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("flush_in", 1'b0, NOP, 1'b1);

    // Asynchronous reset mid-stream
    tick(1'b1, DW'(32'hE), 1'b0, 1'b0);
    tick(1'b1, DW'(32'hF), 1'b0, 1'b0);
    rst = 1'b1;                          lit("rst_async", 1'b0, NOP, 1'b1);
    tick(1'b1, DW'(32'hF), 1'b0, 1'b0);
    rst = 1'b0;                          lit("rst_release", 1'b0, NOP, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("post_rst", 1'b1, DW'(32'hF), 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0);         lit("post_rst_end", 1'b0, NOP, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      rd = DW'({$urandom, $urandom, $urandom});
      tick($urandom_range(0, 9) < 6, rd, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
